// File: rtl/clock_set_ctrl.sv
// MM:SS BCD clock with RUN / SET_MIN / SET_SEC modes and button-driven field editing.
// The field being edited blinks through digit_en; every output comes straight from a flop.
module clock_set_ctrl #(
    parameter int BLINK_CYCLES = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_clr,
    output logic [3:0] secslo,
    output logic [3:0] secshi,
    output logic [3:0] minslo,
    output logic [3:0] minshi,
    output logic [3:0] digit_en,
    output logic [1:0] mode
);

    // state | meaning
    // RUN     | time advances on tick, buttons other than mode ignored
    // SET_MIN | time frozen, inc/clr act on minutes, minutes blink
    // SET_SEC | time frozen, inc/clr act on seconds, seconds blink
    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_MIN = 2'b01,
        SET_SEC = 2'b10
    } state_t;

    localparam int CW = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_CYCLES - 1);

    state_t        state, state_next;
    logic [7:0]    sec, sec_next, min, min_next;
    logic [CW-1:0] blink_cnt, cnt_next;
    logic          blink_phase, phase_next;
    logic [3:0]    en_next;
    logic          restart;

    // Saturating digit checks keep any field inside 00..59.
    function automatic logic [7:0] inc60(input logic [7:0] v);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = v[7:4];
        lo = v[3:0];
        if (lo >= 4'd9) begin
            lo = 4'd0;
            hi = (hi >= 4'd5) ? 4'd0 : hi + 4'd1;
        end else begin
            lo = lo + 4'd1;
        end
        return {hi, lo};
    endfunction

    always_comb begin
        state_next = state;
        sec_next   = sec;
        min_next   = min;
        restart    = 1'b0;
        case (state)
            RUN: begin
                if (tick) begin
                    sec_next = inc60(sec);
                    if (sec == 8'h59) min_next = inc60(min);
                end
                if (btn_mode) begin
                    state_next = SET_MIN;
                    restart    = 1'b1;
                end
            end
            SET_MIN: begin
                if (btn_mode) begin
                    state_next = SET_SEC;
                    restart    = 1'b1;
                end else if (btn_clr) begin
                    min_next = 8'h00;
                    restart  = 1'b1;
                end else if (btn_inc) begin
                    min_next = inc60(min);
                    restart  = 1'b1;
                end
            end
            SET_SEC: begin
                if (btn_mode) begin
                    state_next = RUN;
                    restart    = 1'b1;
                end else if (btn_clr) begin
                    sec_next = 8'h00;
                    restart  = 1'b1;
                end else if (btn_inc) begin
                    sec_next = inc60(sec);
                    restart  = 1'b1;
                end
            end
            default: begin
                state_next = RUN;
                restart    = 1'b1;
            end
        endcase

        cnt_next   = '0;
        phase_next = 1'b1;
        if (!restart && (state == SET_MIN || state == SET_SEC)) begin
            if (blink_cnt == CNT_LAST) begin
                phase_next = ~blink_phase;
            end else begin
                cnt_next   = blink_cnt + CW'(1);
                phase_next = blink_phase;
            end
        end

        // Lit flags follow the post-edge state so digit_en stays aligned with mode.
        case (state_next)
            SET_MIN: en_next = {phase_next, phase_next, 2'b11};
            SET_SEC: en_next = {2'b11, phase_next, phase_next};
            default: en_next = 4'b1111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            sec         <= 8'h00;
            min         <= 8'h00;
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
            digit_en    <= 4'b1111;
        end else begin
            state       <= state_next;
            sec         <= sec_next;
            min         <= min_next;
            blink_cnt   <= cnt_next;
            blink_phase <= phase_next;
            digit_en    <= en_next;
        end
    end

    assign secslo = sec[3:0];
    assign secshi = sec[7:4];
    assign minslo = min[3:0];
    assign minshi = min[7:4];
    assign mode   = state;

endmodule

// File: doc/clock_set_ctrl.md
CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 The block SHALL have parameter BLINK_CYCLES, default 25_000_000, meaning the number of clk cycles per blink half-period; legal range is 2 or more.
REQ-002 Port clk, input, 1 bit: the single system clock; all state SHALL change on its rising edge only.
REQ-003 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 Port tick, input, 1 bit: 1 Hz enable pulse, exactly one clk cycle wide.
REQ-005 Port btn_mode, input, 1 bit: debounced single-cycle pulse that advances the mode.
REQ-006 Port btn_inc, input, 1 bit: debounced single-cycle pulse that increments the selected field.
REQ-007 Port btn_clr, input, 1 bit: debounced single-cycle pulse that zeroes the selected field.
REQ-008 Ports secslo and secshi, output, 4 bits each: BCD seconds ones and tens digits.
REQ-009 Ports minslo and minshi, output, 4 bits each: BCD minutes ones and tens digits.
REQ-010 Port digit_en, output, 4 bits: per-digit lit flags, bit order {minshi, minslo, secshi, secslo}; 1 means lit.
REQ-011 Port mode, output, 2 bits: current state encoding, RUN=2'b00, SET_MIN=2'b01, SET_SEC=2'b10.

Function
REQ-012 The FSM SHALL have exactly three states, RUN, SET_MIN and SET_SEC; encoding 2'b11 is unreachable and SHALL recover to RUN on the next clock.
REQ-013 btn_mode SHALL advance the state RUN -> SET_MIN -> SET_SEC -> RUN, one step per pulse, effective on the next clock.
REQ-014 In RUN, tick SHALL increment the time by one second on the next clock, as follows:
- secslo counts 0..9; secshi counts 0..5.
- Carry at 59 s sets seconds to 00 and increments minutes.
- minslo counts 0..9; minshi counts 0..5.
- 59:59 wraps to 00:00.
REQ-015 In SET_MIN and SET_SEC, tick SHALL be ignored (time frozen).
REQ-016 In SET_MIN, btn_inc SHALL increment minutes modulo 60 with no effect on seconds, and btn_clr SHALL set minutes to 00.
REQ-017 In SET_SEC, btn_inc SHALL increment seconds modulo 60 with no carry into minutes, and btn_clr SHALL set seconds to 00.
REQ-018 In RUN, btn_inc and btn_clr SHALL be ignored.
REQ-019 Same-cycle priority SHALL be btn_mode > btn_clr > btn_inc; a lower-priority button asserted in the same cycle SHALL be discarded.
REQ-020 If tick and btn_mode coincide in RUN, the tick SHALL be applied and the state SHALL advance to SET_MIN in that same clock.
REQ-021 Blink timer behaviour:
- blink_cnt counts 0..BLINK_CYCLES-1 only while in SET_MIN or SET_SEC.
- On reaching BLINK_CYCLES-1, blink_cnt SHALL wrap to 0 and blink_phase SHALL toggle.
REQ-022 On entry to any state, and on any accepted btn_inc or btn_clr, the block SHALL set blink_cnt=0 and blink_phase=1 on the same clock edge.
REQ-023 digit_en SHALL be registered and SHALL take these values:
- RUN: 4'b1111.
- SET_MIN: {blink_phase, blink_phase, 1, 1}.
- SET_SEC: {1, 1, blink_phase, blink_phase}.
REQ-024 All outputs SHALL be driven directly from registers, with no combinational path from any input to any output; button response latency SHALL be 1 clk.

Reset
REQ-025 While reset=1 at a clock edge, the block SHALL set:
- all four BCD digits = 0;
- mode = RUN;
- digit_en = 4'b1111;
- blink_cnt = 0 and blink_phase = 1.
REQ-026 reset SHALL override every other input in the same cycle.
REQ-027 Reset asserted mid-set SHALL return the block to RUN at 00:00.
REQ-028 Digit registers SHALL never hold non-BCD values or values beyond 59 for either field, under any input sequence.

Verification (bench uses BLINK_CYCLES=4)
REQ-029 Roll-over: preload 59:58 via SET_MIN and SET_SEC, return to RUN, apply 2 ticks -> 59:59, then 00:00; digit_en stays 4'b1111.
REQ-030 Field isolation: in SET_SEC at 12:59 apply btn_inc -> 12:00 (minutes unchanged); apply tick -> still 12:00.
REQ-031 Same-cycle priority:
- In SET_MIN at 05:00, btn_mode+btn_inc together -> mode=SET_SEC, time 05:00.
- In SET_MIN at 05:00, btn_clr+btn_inc together -> 00:00.
REQ-032 Blink timing: enter SET_MIN -> digit_en=4'b1111 for 4 clk, 4'b0011 for the next 4 clk, then 4'b1111 again; a btn_inc during the 4'b0011 phase -> 4'b1111 on the next clk.
REQ-033 Reset mid-operation: in SET_SEC at 33:21, assert reset with btn_inc high -> next clk shows 00:00, mode=2'b00, digit_en=4'b1111.
REQ-034 Tick/mode coincidence: in RUN at 00:09, tick+btn_mode together -> 00:10 and mode=2'b01 on the same clock.
